store_buffer: RTL

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_pkg.sv | 18 +
 rtl/store_buffer_fifo.sv | 58 +++++
 rtl/store_buffer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared widths, FSM state and entry type for the store buffer
package store_buffer_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    SB_IDLE  = 2'd0,
    SB_DRAIN = 2'd1,
    SB_FLUSH = 2'd2
  } sb_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_fifo.sv
// rtl/store_buffer_fifo.sv - circular storage, head/tail pointers, occupancy and per-slot valid bits
module store_buffer_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enq,
  input  sb_entry_t       enq_entry,
  input  logic            deq,
  output sb_entry_t       head_entry,
  output logic [CW-1:0]   count,
  output logic [CW-1:0]   count_next,
  output logic            empty,
  output logic            full,
  output logic [PW-1:0]   head_ptr,
  output logic [DEPTH-1:0] valid,
  output sb_entry_t       slots [DEPTH]
);

  logic [PW-1:0] tail_ptr;

  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign head_entry = slots[head_ptr];
  assign count_next = count + CW'(enq) - CW'(deq);

  // Storage array: written at the tail, never reset (valid bits qualify it)
  always_ff @(posedge clk) begin
    if (enq) begin
      slots[tail_ptr] <= enq_entry;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      valid    <= '0;
    end else begin
      if (enq) begin
        tail_ptr        <= tail_ptr + 1'b1;
        valid[tail_ptr] <= 1'b1;
      end
      if (deq) begin
        head_ptr        <= head_ptr + 1'b1;
        valid[head_ptr] <= 1'b0;
      end
      count <= count_next;
    end
  end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - CPU store buffer with drain/flush FSM; load forwarding when STORE_BUFFER_FWD_EN is defined
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_we,
  input  logic                 cpu_re,
  input  logic [ADDR_W-1:0]    cpu_adr,
  input  logic [DATA_W-1:0]    cpu_wdata,
  input  logic                 flush,
  output logic                 stall,
  output logic                 fwd_hit,
  output logic [DATA_W-1:0]    fwd_data,
  output logic                 mem_valid,
  input  logic                 mem_ready,
  output logic [ADDR_W-1:0]    mem_adr,
  output logic [DATA_W-1:0]    mem_wdata,
  output logic                 empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_state_t        state;
  sb_entry_t        head_entry;
  sb_entry_t        slots [DEPTH];
  logic [CW-1:0]    count_next;
  logic             full;
  logic [PW-1:0]    head_ptr;
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] match;
  logic             hit_any;
  logic [DATA_W-1:0] youngest_data;
  logic [PW-1:0]    idx;
  logic             load_block;
  logic             enq;
  logic             deq;

  store_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .enq        (enq),
    .enq_entry  ({cpu_adr, cpu_wdata}),
    .deq        (deq),
    .head_entry (head_entry),
    .count      (count),
    .count_next (count_next),
    .empty      (empty),
    .full       (full),
    .head_ptr   (head_ptr),
    .valid      (valid),
    .slots      (slots)
  );

  assign mem_valid = !empty;
  assign mem_adr   = head_entry.adr;
  assign mem_wdata = head_entry.data;
  assign deq       = mem_valid && mem_ready;
  assign enq       = cpu_we && !stall;

  // Address match against every valid entry; the head leaving this cycle still counts
  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid[i] && (slots[i].adr == cpu_adr);
    end
  end

  assign hit_any = |match;

  // Walk from oldest to youngest so the last matching entry wins
  always_comb begin
    youngest_data = '0;
    idx           = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_ptr + PW'(k);
      if (match[idx]) begin
        youngest_data = slots[idx].data;
      end
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  assign fwd_hit    = cpu_re && hit_any;
  assign fwd_data   = fwd_hit ? youngest_data : '0;
  assign load_block = 1'b0;
`else
  logic unused_youngest;
  assign unused_youngest = ^youngest_data;
  assign fwd_hit    = 1'b0;
  assign fwd_data   = '0;
  assign load_block = cpu_re && hit_any;
`endif

  // Stall: full buffer on a store, any CPU access while flushing, or an unforwardable load hit
  always_comb begin
    stall = ((state == SB_FLUSH) && (cpu_we || cpu_re))
         || (cpu_we && full)
         || load_block;
  end

  // Mode FSM: flush holds until the buffer has fully drained
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= SB_IDLE;
    end else begin
      unique case (state)
        SB_FLUSH: state <= (count_next == '0) ? SB_IDLE : SB_FLUSH;
        default: begin
          if (flush && !empty && (count_next != '0)) begin
            state <= SB_FLUSH;
          end else begin
            state <= (count_next == '0) ? SB_IDLE : SB_DRAIN;
          end
        end
      endcase
    end
  end

endmodule
